// File: rtl/pipe_pkg.sv
// pipe_pkg -- shared definitions for the EX/MEM and MEM/WB pipeline registers.
// Holds the bundle layouts and the MEM-stage FSM state encoding. The EX/MEM
// register also uses this package, so every field position is defined here.
package pipe_pkg;

  localparam int EXMEM_W = 24;
  localparam int MEMWB_W = 22;
  localparam int DATA_W  = 8;
  localparam int REG_W   = 4;

  // EX/MEM bundle, MSB first:
  // [23] reg_write, [22] rd_en, [21] wr_en, [20] mem_to_reg,
  // [19:16] reg_dest, [15:8] data_to_mem, [7:0] alu_result
  typedef struct packed {
    logic              reg_write;
    logic              rd_en;
    logic              wr_en;
    logic              mem_to_reg;
    logic [REG_W-1:0]  reg_dest;
    logic [DATA_W-1:0] data_to_mem;
    logic [DATA_W-1:0] alu_result;
  } exmem_t;

  // MEM/WB bundle, MSB first:
  // [21] reg_write, [20] mem_to_reg, [19:16] reg_dest,
  // [15:8] mem_rdata, [7:0] alu_result
  typedef struct packed {
    logic              reg_write;
    logic              mem_to_reg;
    logic [REG_W-1:0]  reg_dest;
    logic [DATA_W-1:0] mem_rdata;
    logic [DATA_W-1:0] alu_result;
  } memwb_t;

  typedef enum logic {
    IDLE    = 1'b0,
    RD_WAIT = 1'b1
  } state_t;

  // Build a MEM/WB bundle from an EX/MEM bundle plus the memory read data.
  function automatic memwb_t make_memwb(input exmem_t b, input logic [DATA_W-1:0] rdata);
    memwb_t m;
    m.reg_write  = b.reg_write;
    m.mem_to_reg = b.mem_to_reg;
    m.reg_dest   = b.reg_dest;
    m.mem_rdata  = rdata;
    m.alu_result = b.alu_result;
    return m;
  endfunction

endpackage

// File: rtl/data_mem_sp.sv
// data_mem_sp -- single-port data memory, DEPTH x 8, synchronous write,
// registered read.
// Ports:
//   nclk    clock (rising edge)
//   rst     asynchronous active-high reset, clears only the read register
//   i_we    write enable: mem[i_addr] <= i_wdata at the edge
//   i_re    read enable: o_rdata <= mem[i_addr] at the edge
//   i_addr  word address
//   i_wdata write data
//   o_rdata registered read data (holds its value while i_re is low)
// The array itself is never reset, so it can map onto block RAM.
module data_mem_sp #(
  parameter int DEPTH = 256,
  parameter int AW    = 8
) (
  input  logic          nclk,
  input  logic          rst,
  input  logic          i_we,
  input  logic          i_re,
  input  logic [AW-1:0] i_addr,
  input  logic [7:0]    i_wdata,
  output logic [7:0]    o_rdata
);

  logic [7:0] r_mem [DEPTH];
  logic [7:0] r_rdata;

  always_ff @(posedge nclk) begin
    if (i_we) begin
      r_mem[i_addr] <= i_wdata;
    end
  end

  always_ff @(posedge nclk or posedge rst) begin
    if (rst) begin
      r_rdata <= '0;
    end else if (i_re) begin
      r_rdata <= r_mem[i_addr];
    end
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/mem_stage_memwb.sv
// mem_stage_memwb -- pipeline MEM stage with the MEM/WB register.
// Loads take two cycles: the first edge reads memory and emits a bubble
// while stall holds the EX/MEM bundle, and the second edge emits the result.
// Stores and ALU pass-through bundles complete in one cycle.
// Ports:
//   nclk      clock (rising edge)
//   rst       asynchronous active-high reset
//   exmem_in  EX/MEM bundle (pipe_pkg::exmem_t layout)
//   stall     upstream hold request, high only in the first cycle of a load
//   memwb_out registered MEM/WB bundle (pipe_pkg::memwb_t layout)
//   wb_data   write-back value: mem_rdata if mem_to_reg, otherwise alu_result
//   err       sticky flag: an accepted bundle had both rd_en and wr_en set
// MEM_DEPTH must not exceed 256, because the address comes from the 8-bit alu_result.
module mem_stage_memwb
  import pipe_pkg::*;
#(
  parameter int MEM_DEPTH = 256
) (
  input  logic               nclk,
  input  logic               rst,
  input  logic [EXMEM_W-1:0] exmem_in,
  output logic               stall,
  output logic [MEMWB_W-1:0] memwb_out,
  output logic [DATA_W-1:0]  wb_data,
  output logic               err
);

  localparam int AW = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;

  exmem_t            w_in;
  logic [AW-1:0]     w_addr;
  logic              w_is_load;
  logic              w_is_store;
  logic [DATA_W-1:0] w_rd_data_q;

  state_t r_state;
  memwb_t r_memwb;
  logic   r_err;

  assign w_in   = exmem_in;
  assign w_addr = AW'(w_in.alu_result);

  // When rd_en and wr_en are both set, the bundle is handled as a store.
  assign w_is_load  = (r_state == IDLE) & w_in.rd_en & ~w_in.wr_en;
  assign w_is_store = (r_state == IDLE) & w_in.wr_en;

  // The stall is Mealy, so the hold is requested in the same cycle the load is presented.
  assign stall = w_is_load & ~rst;

  // The memory read register is the rd_data_q holding register for the load in flight.
  data_mem_sp #(
    .DEPTH (MEM_DEPTH),
    .AW    (AW)
  ) u_mem (
    .nclk    (nclk),
    .rst     (rst),
    .i_we    (w_is_store & ~rst),
    .i_re    (w_is_load),
    .i_addr  (w_addr),
    .i_wdata (w_in.data_to_mem),
    .o_rdata (w_rd_data_q)
  );

  always_ff @(posedge nclk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_memwb <= '0;
      r_err   <= 1'b0;
    end else if (r_state == IDLE) begin
      if (w_in.rd_en & w_in.wr_en) begin
        r_err <= 1'b1;
      end
      if (w_is_load) begin
        r_memwb <= '0;
        r_state <= RD_WAIT;
      end else begin
        r_memwb <= make_memwb(w_in, '0);
      end
    end else begin
      // Upstream was frozen, so exmem_in is still the load bundle.
      r_memwb <= make_memwb(w_in, w_rd_data_q);
      r_state <= IDLE;
    end
  end

  assign memwb_out = r_memwb;
  assign err       = r_err;
  assign wb_data   = r_memwb.mem_to_reg ? r_memwb.mem_rdata : r_memwb.alu_result;

endmodule
